// File: rtl/serial_adder_acc.sv
// Digit-serial add/sub/accumulate unit: one DIGIT-wide adder slice plus a carry flop,
// with valid/ready handshakes on both sides and registered result flags.
module serial_adder_acc #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder_acc: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [1:0]       r_mode;
    logic [CW-1:0]    r_step;
    logic             r_c;
    logic             r_sa;
    logic             r_sb;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_out_hs;
    logic             w_cin;
    logic [WIDTH-1:0] w_opb;
    logic [DIGIT:0]   w_dfull;
    logic [WIDTH-1:0] w_next_res;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_RUN) && (r_step == CW'(N - 1));
    assign w_out_hs = out_ready && (r_state == S_DONE);
    assign w_cin    = (mode == 2'b01) || (mode == 2'b11);

    always_comb begin
        w_opb = b;
        unique case (mode)
            2'b01:   w_opb = ~b;
            2'b10:   w_opb = r_acc;
            default: w_opb = b;
        endcase
    end

    assign w_dfull = (DIGIT+1)'(r_a[DIGIT-1:0])
                   + (DIGIT+1)'(r_b[DIGIT-1:0])
                   + (DIGIT+1)'(r_c);

    // Result digits enter at the top so the word is aligned after N steps.
    assign w_next_res = (r_res >> DIGIT)
                      | (WIDTH'(w_dfull[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_mode <= 2'b00;
            r_step <= '0;
            r_c    <= 1'b0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= a;
                r_b    <= w_opb;
                r_c    <= w_cin;
                r_mode <= mode;
                r_step <= '0;
                r_sa   <= a[WIDTH-1];
                r_sb   <= w_opb[WIDTH-1];
            end else if (r_state == S_RUN) begin
                r_a    <= r_a >> DIGIT;
                r_b    <= r_b >> DIGIT;
                r_c    <= w_dfull[DIGIT];
                r_res  <= w_next_res;
                r_step <= w_last ? '0 : r_step + CW'(1);
                if (w_last) begin
                    r_sum  <= w_next_res;
                    r_cout <= w_dfull[DIGIT];
                    // Same-sign operands giving a different-sign result.
                    r_ovf  <= (r_sa == r_sb) && (w_next_res[WIDTH-1] != r_sa);
                end
            end
            if (w_out_hs && r_mode == 2'b10) r_acc <= r_sum;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Randomised bench for serial_adder_acc (DIGIT=1 and DIGIT=4 instances)
// against an integer-arithmetic reference model.
module tb_serial_adder_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv1 = 0, or1 = 0, ir1, ov1, co1, vf1, bz1;
    logic [7:0] a1 = 0, b1 = 0, s1;
    logic [1:0] m1 = 0;
    logic       iv4 = 0, or4 = 0, ir4, ov4, co4, vf4, bz4;
    logic [7:0] a4 = 0, b4 = 0, s4;
    logic [1:0] m4 = 0;

    serial_adder_acc #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .mode(m1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .carry_out(co1), .overflow(vf1), .busy(bz1)
    );

    serial_adder_acc #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .mode(m4), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .carry_out(co4), .overflow(vf4), .busy(bz4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit [7:0] macc [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int d, input bit [1:0] m,
                                  input bit [7:0] av, input bit [7:0] bv,
                                  output bit [7:0] s, output bit c, output bit v);
        bit [7:0] ob;
        int ci, full, sr;
        ob   = (m == 2'b01) ? ~bv : (m == 2'b10) ? macc[d] : bv;
        ci   = (m == 2'b01 || m == 2'b11) ? 1 : 0;
        full = int'(av) + int'(ob) + ci;
        s    = full[7:0];
        c    = full[8];
        sr   = int'($signed(av)) + int'($signed(ob)) + ci;
        v    = (sr > 127) || (sr < -128);
    endfunction

    function automatic logic g_ir(input int d); return d ? ir4 : ir1; endfunction
    function automatic logic g_ov(input int d); return d ? ov4 : ov1; endfunction
    function automatic logic [7:0] g_s(input int d); return d ? s4 : s1; endfunction
    function automatic logic g_co(input int d); return d ? co4 : co1; endfunction
    function automatic logic g_vf(input int d); return d ? vf4 : vf1; endfunction

    task automatic drive(input int d, input logic v, input bit [1:0] m,
                         input bit [7:0] av, input bit [7:0] bv);
        if (d != 0) begin iv4 = v; m4 = m; a4 = av; b4 = bv; end
        else        begin iv1 = v; m1 = m; a1 = av; b1 = bv; end
    endtask

    task automatic set_ordy(input int d, input logic r);
        if (d != 0) or4 = r; else or1 = r;
    endtask

    // Issue one op, check latency and result, then hold backpressure for hold cycles.
    task automatic run_op(input int d, input bit [1:0] m, input bit [7:0] av,
                          input bit [7:0] bv, input int hold);
        bit [7:0] es;
        bit ec, ev;
        int w, lat;
        model(d, m, av, bv, es, ec, ev);
        w = 0;
        while (!g_ir(d) && w < 20) begin @(posedge clk); #1; w++; end
        chk("in_ready_wait", 32'(g_ir(d)), 32'd1);
        drive(d, 1'b1, m, av, bv);
        @(posedge clk); #1;
        drive(d, 1'b0, m, av, bv);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (g_ov(d)) break;
        end
        chk("latency", 32'(lat), d ? 32'd2 : 32'd8);
        chk("sum", 32'(g_s(d)), 32'(es));
        chk("carry", 32'(g_co(d)), 32'(ec));
        chk("ovf", 32'(g_vf(d)), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_sum", 32'(g_s(d)), 32'(es));
            chk("hold_valid", 32'(g_ov(d)), 32'd1);
        end
        set_ordy(d, 1'b1);
        @(posedge clk); #1;
        set_ordy(d, 1'b0);
        chk("idle_ready", 32'(g_ir(d)), 32'd1);
        chk("idle_valid", 32'(g_ov(d)), 32'd0);
        if (m == 2'b10) macc[d] = es;
    endtask

    initial begin
        bit [7:0] ra, rb;
        macc[0] = 0;
        macc[1] = 0;
        #12;
        chk("rst_ready", 32'(ir1), 32'd1);
        chk("rst_valid", 32'(ov1), 32'd0);
        chk("rst_busy", 32'(bz1), 32'd0);
        chk("rst_sum", 32'(s1), 32'd0);
        chk("rst_flags", {30'd0, co1, vf1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 2'b00, 8'hFF, 8'h01, 0);
        run_op(0, 2'b01, 8'h05, 8'h07, 0);
        run_op(0, 2'b01, 8'h80, 8'h01, 0);
        chk("sub_ovf_dir", 32'(vf1), 32'd1);
        run_op(0, 2'b10, 8'h10, 8'h00, 0);
        run_op(0, 2'b10, 8'h10, 8'h00, 0);
        run_op(0, 2'b10, 8'h10, 8'h00, 0);
        chk("acc_30", 32'(s1), 32'h30);
        run_op(0, 2'b00, 8'h01, 8'h01, 0);
        run_op(0, 2'b10, 8'h01, 8'h00, 0);
        chk("acc_31", 32'(s1), 32'h31);

        // Backpressure with in_valid/a toggling in DONE
        drive(0, 1'b1, 2'b00, 8'h22, 8'h33);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b00, 8'h22, 8'h33);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_valid", 32'(ov1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(0, i[0] ? 1'b0 : 1'b1, 2'b00, 8'(i * 37), 8'h11);
            @(posedge clk); #1;
            chk("bp_sum", 32'(s1), 32'h55);
            chk("bp_ready", 32'(ir1), 32'd0);
            chk("bp_busy", 32'(bz1), 32'd1);
        end
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        chk("bp_release", 32'(ir1), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_second", 32'(bz1), 32'd0);

        // Reset during RUN
        drive(0, 1'b1, 2'b00, 8'h44, 8'h44);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov1), 32'd0);
        chk("mid_rst_busy", 32'(bz1), 32'd0);
        chk("mid_rst_sum", 32'(s1), 32'd0);
        macc[0] = 0;
        macc[1] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 2'b11, 8'h7F, 8'h00, 0);
        chk("adc_80", 32'(s1), 32'h80);
        run_op(0, 2'b10, 8'h01, 8'h00, 0);
        chk("acc_cleared", 32'(s1), 32'h01);

        run_op(1, 2'b00, 8'h9A, 8'h76, 0);
        chk("d4_sum", 32'(s4), 32'h10);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(i % 3 == 0 ? 1 : 0, 2'($urandom_range(0, 3)), ra, rb,
                   int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
